// File: rtl/timer_controller.sv
`default_nettype none
// ============================================================================
// Module   : timer_controller
// Brief    : Memory-mapped 32-bit timer with prescaler, one-shot/periodic
//            compare and level interrupt. Prescaler built only when
//            TIMER_CTRL_PRESCALER_EN is defined.
// Revision : 1.0
// ============================================================================
module timer_controller #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              irq
);
    localparam int WORD_W = ADDR_W - 2;
    localparam logic [WORD_W-1:0] A_CTRL     = WORD_W'(0);
    localparam logic [WORD_W-1:0] A_PRESCALE = WORD_W'(1);
    localparam logic [WORD_W-1:0] A_COUNT    = WORD_W'(2);
    localparam logic [WORD_W-1:0] A_COMPARE  = WORD_W'(3);
    localparam logic [WORD_W-1:0] A_STATUS   = WORD_W'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              periodic;
    logic              irq_en;
    logic              match;
    logic [31:0]       count;
    logic [31:0]       compare;
    logic [WORD_W-1:0] word;
    logic              wr;
    logic              wr_ctrl;
    logic              wr_count;
    logic              wr_compare;
    logic              wr_status;
    logic              start;
    logic              tick_due;
    logic              tick;
    logic              hit;
    logic [15:0]       prescale_rd;
    logic [31:0]       rd_data;
    logic              unused_addr_bits;

    assign word             = req_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^req_addr[1:0];
    assign wr               = req_valid & req_we;
    assign wr_ctrl          = wr & (word == A_CTRL);
    assign wr_count         = wr & (word == A_COUNT);
    assign wr_compare       = wr & (word == A_COMPARE);
    assign wr_status        = wr & (word == A_STATUS);
    assign start            = wr_ctrl & req_wdata[0] & (state != RUN);

`ifdef TIMER_CTRL_PRESCALER_EN
    logic        wr_prescale;
    logic [15:0] prescale;
    logic [15:0] pcnt;

    assign wr_prescale = wr & (word == A_PRESCALE);
    assign tick_due    = (pcnt == prescale);
    assign prescale_rd = prescale;

    // pcnt compares for equality only, so a PRESCALE lowered below pcnt
    // runs pcnt through 0xFFFF and back to 0 before the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= 16'd0;
            pcnt     <= 16'd0;
        end else begin
            if (wr_prescale) prescale <= req_wdata[15:0];
            if (start || wr_count) pcnt <= 16'd0;
            else if (state == RUN) pcnt <= tick_due ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign tick_due    = 1'b1;
    assign prescale_rd = 16'd0;
`endif

    // A software COUNT write in the same cycle suppresses the tick entirely.
    assign tick = (state == RUN) & tick_due & ~wr_count;
    assign hit  = tick & (count == compare);
    assign irq  = match & irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (wr_ctrl) begin
            if (!req_wdata[0])     state_nxt = IDLE;
            else if (state != RUN) state_nxt = RUN;
        end else if (hit && !periodic) begin
            state_nxt = EXPIRED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            count    <= 32'd0;
            compare  <= 32'd0;
            match    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                periodic <= req_wdata[1];
                irq_en   <= req_wdata[2];
            end
            if (wr_compare) compare <= req_wdata;
            if (wr_count) begin
                count <= req_wdata;
            end else if (tick) begin
                if (!hit)          count <= count + 32'd1;
                else if (periodic) count <= 32'd0;
            end
            // Hardware set has priority over a software clear.
            if (hit)                            match <= 1'b1;
            else if (wr_status && req_wdata[0]) match <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (word)
            A_CTRL:     rd_data = {29'd0, irq_en, periodic, (state == RUN)};
            A_PRESCALE: rd_data = {16'd0, prescale_rd};
            A_COUNT:    rd_data = count;
            A_COMPARE:  rd_data = compare;
            A_STATUS:   rd_data = {31'd0, match};
            default:    rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= req_valid;
            resp_rdata <= (req_valid && !req_we) ? rd_data : 32'd0;
        end
    end
endmodule
`default_nettype wire
